// File: rtl/reg_dump_tx_pkg.sv
// -----------------------------------------------------------------------------
// reg_dump_tx_pkg
//   Shared definitions for the register-dump UART transmitter: sequencer state
//   encodings, line-format constants and the character generator that turns a
//   32-bit word plus a character index into the ASCII byte for that position.
// -----------------------------------------------------------------------------
package reg_dump_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SEND  = 2'd2
   } state_t;

   localparam logic [7:0] ASCII_CR       = 8'h0D;
   localparam logic [7:0] ASCII_LF       = 8'h0A;
   localparam logic [3:0] BYTES_PER_LINE = 4'd10;
   localparam logic [3:0] LAST_CHAR      = BYTES_PER_LINE - 4'd1;
   localparam logic [4:0] LAST_REG       = 5'd31;

   // Uppercase hex digit: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + {4'h0, nib};
      return 8'h37 + {4'h0, nib};
   endfunction

   // Character idx of a line: 0..7 are nibbles MSB first, 8 is CR, 9 is LF.
   function automatic logic [7:0] line_char(input logic [31:0] word,
                                            input logic [3:0]  idx);
      logic [3:0] nib;
      case (idx[2:0])
         3'd0:    nib = word[31:28];
         3'd1:    nib = word[27:24];
         3'd2:    nib = word[23:20];
         3'd3:    nib = word[19:16];
         3'd4:    nib = word[15:12];
         3'd5:    nib = word[11:8];
         3'd6:    nib = word[7:4];
         default: nib = word[3:0];
      endcase
      if (idx < 4'd8)  return hex_ascii(nib);
      if (idx == 4'd8) return ASCII_CR;
      return ASCII_LF;
   endfunction

endpackage

// File: rtl/reg_dump_tx_uart.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
//   8N1 byte serializer. A byte is accepted when valid && ready; the start bit
//   appears on tx in the following cycle. ready is also asserted during the
//   last cycle of the stop bit so a new byte can follow with no idle gap.
//
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     tx_byte     byte to send
//     valid       tx_byte is offered this cycle
//     tx          serial output, idle high
//     ready       a byte offered this cycle will be accepted
// -----------------------------------------------------------------------------
module uart_tx_byte #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_byte,
   input  logic       valid,
   output logic       tx,
   output logic       ready
);

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   logic [15:0] r_baud;
   logic [3:0]  r_bit;
   logic [8:0]  r_frame;
   logic        r_busy;
   logic        r_tx;
   logic        w_bit_end;

   assign w_bit_end = (r_baud == BAUD_LAST);
   assign ready     = !r_busy || (w_bit_end && (r_bit == 4'd9));
   assign tx        = r_tx;

   // r_frame holds the bits still to be sent after the start bit: data LSB
   // first, then the stop bit, shifted in as 1s from the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud  <= '0;
         r_bit   <= '0;
         r_frame <= '0;
         r_busy  <= 1'b0;
         r_tx    <= 1'b1;
      end else if (valid && ready) begin
         r_frame <= {1'b1, tx_byte};
         r_tx    <= 1'b0;
         r_bit   <= '0;
         r_baud  <= '0;
         r_busy  <= 1'b1;
      end else if (r_busy) begin
         if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit == 4'd9) begin
               r_busy <= 1'b0;
               r_tx   <= 1'b1;
               r_bit  <= '0;
            end else begin
               r_bit   <= r_bit + 4'd1;
               r_tx    <= r_frame[0];
               r_frame <= {1'b1, r_frame[8:1]};
            end
         end else begin
            r_baud <= r_baud + 16'd1;
         end
      end
   end

endmodule

// File: rtl/reg_dump_tx.sv
// -----------------------------------------------------------------------------
// reg_dump_tx
//   Dumps a 32 x 32-bit register file over UART as 32 text lines of eight
//   uppercase hex digits followed by CR LF, register 0 first.
//
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     start       dump request, honoured only when idle
//     rd_addr     register-file read address (current register index)
//     rd_data     register-file read data, combinational from rd_addr
//     tx          UART 8N1 serial output, idle high
//     busy        dump in progress
//     done        one-cycle pulse when the last stop bit has finished
// -----------------------------------------------------------------------------
module reg_dump_tx
   import reg_dump_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [4:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   state_t      r_state;
   logic [31:0] r_word;
   logic [3:0]  r_char;
   logic [4:0]  r_reg;
   logic        r_busy;
   logic        r_done;

   logic        w_ready;
   logic        w_valid;
   logic [7:0]  w_byte;

   assign rd_addr = r_reg;
   assign busy    = r_busy;
   assign done    = r_done;

   // The first character of a line is taken straight from rd_data during
   // FETCH so its start bit lines up with the word being latched; the rest
   // come from the latched word so later register writes cannot leak in.
   always_comb begin
      w_valid = 1'b0;
      w_byte  = line_char(r_word, r_char + 4'd1);
      case (r_state)
         ST_FETCH: begin
            w_valid = 1'b1;
            w_byte  = line_char(rd_data, 4'd0);
         end
         ST_SEND: w_valid = w_ready && (r_char != LAST_CHAR);
         default: w_valid = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_word  <= '0;
         r_char  <= '0;
         r_reg   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // r_done marks the completion cycle, where start is ignored.
               if (start && !r_done) begin
                  r_state <= ST_FETCH;
                  r_busy  <= 1'b1;
                  r_reg   <= '0;
                  r_char  <= '0;
               end
            end
            ST_FETCH: begin
               r_word  <= rd_data;
               r_char  <= '0;
               r_state <= ST_SEND;
            end
            ST_SEND: begin
               if (w_ready) begin
                  if (r_char != LAST_CHAR) begin
                     r_char <= r_char + 4'd1;
                  end else if (r_reg == LAST_REG) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_reg   <= r_reg + 5'd1;
                     r_state <= ST_FETCH;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_byte (w_byte),
      .valid   (w_valid),
      .tx      (tx),
      .ready   (w_ready)
   );

endmodule
